// File: rtl/fixed_p_div_pkg.sv
// Shared types and helpers for the sequential signed fixed-point divider.
// State encoding, size functions and the sign-apply helper live here.
package fixed_p_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam int MAX_W = 64;

    function automatic int div_n(int w, int f);
        return w + f;
    endfunction

    function automatic int div_cnt_w(int w, int f);
        return $clog2(w + f + 1);
    endfunction

    function automatic logic [MAX_W-1:0] apply_sign(
        logic [MAX_W-1:0] mag,
        logic             neg
    );
        return neg ? (~mag + 1'b1) : mag;
    endfunction

endpackage

// File: rtl/fixed_p_std_sdiv_seq_if.sv
// Operand/result bundle of the sequential divider.
// The controller drives go/left/right; the divider returns results and done.
interface fixed_p_std_sdiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             go;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             done;

    modport master (
        output go, left, right,
        input  out_quotient, out_remainder, done
    );

    modport slave (
        input  go, left, right,
        output out_quotient, out_remainder, done
    );
endinterface

// File: rtl/fixed_p_div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// subtract the divisor when it fits, and emit the quotient bit.
module fixed_p_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The remainder is always below the divisor, so the difference
    // fits in WIDTH bits even though the compare needs WIDTH+1.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted[WIDTH-1:0] - div_i;
        q_o     = (shifted >= {1'b0, div_i});
        rem_o   = q_o ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/fixed_p_std_sdiv_seq.sv
// Multi-cycle signed fixed-point divider, one quotient bit per cycle.
// Magnitudes are divided unsigned; signs are re-applied on completion.
module fixed_p_std_sdiv_seq
    import fixed_p_div_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 24
) (
    input logic                   clk,
    input logic                   reset,
    fixed_p_std_sdiv_seq_if.slave bus
);

    localparam int N  = div_n(INT_WIDTH + FRACT_WIDTH, FRACT_WIDTH);
    localparam int CW = div_cnt_w(INT_WIDTH + FRACT_WIDTH, FRACT_WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic             lsgn_q, lsgn_d;
    logic             rsgn_q, rsgn_d;
    logic [WIDTH-1:0] oq_q, oq_d;
    logic [WIDTH-1:0] or_q, or_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] abs_l;
    logic [WIDTH-1:0] abs_r;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    fixed_p_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[N-1]),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Most-negative input negates to itself, read back as unsigned 2^(W-1).
    assign abs_l = bus.left[WIDTH-1]  ? (~bus.left + 1'b1)  : bus.left;
    assign abs_r = bus.right[WIDTH-1] ? (~bus.right + 1'b1) : bus.right;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        left_d  = left_q;
        lsgn_d  = lsgn_q;
        rsgn_d  = rsgn_q;
        oq_d    = oq_q;
        or_d    = or_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.go) begin
                    dvd_d   = {abs_l, {FRACT_WIDTH{1'b0}}};
                    dvs_d   = abs_r;
                    rem_d   = '0;
                    quo_d   = '0;
                    left_d  = bus.left;
                    lsgn_d  = bus.left[WIDTH-1];
                    rsgn_d  = bus.right[WIDTH-1];
                    cnt_d   = CW'(N);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                dvd_d = dvd_q << 1;
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (dvs_q == '0) begin
                    oq_d = '0;
                    or_d = left_q;
                end else begin
                    oq_d = WIDTH'(apply_sign(MAX_W'(quo_q), lsgn_q ^ rsgn_q));
                    or_d = WIDTH'(apply_sign(MAX_W'(rem_q), lsgn_q));
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            left_q  <= '0;
            lsgn_q  <= 1'b0;
            rsgn_q  <= 1'b0;
            oq_q    <= '0;
            or_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            left_q  <= left_d;
            lsgn_q  <= lsgn_d;
            rsgn_q  <= rsgn_d;
            oq_q    <= oq_d;
            or_q    <= or_d;
            done_q  <= done_d;
        end
    end

    assign bus.out_quotient  = oq_q;
    assign bus.out_remainder = or_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_fixed_p_std_sdiv_seq.sv
// Directed bench for the sequential divider at WIDTH=8, Q4.4, N=12.
// Expected values are hand-computed fixed-point quotients.
module tb_fixed_p_std_sdiv_seq;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    fixed_p_std_sdiv_seq_if #(.WIDTH(8)) bus ();

    fixed_p_std_sdiv_seq #(
        .WIDTH       (8),
        .INT_WIDTH   (4),
        .FRACT_WIDTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op; lat is the edge index (go edge = 0) after which done is seen.
    task automatic run_op(
        input  logic [7:0] l,
        input  logic [7:0] r,
        output logic [7:0] q,
        output logic [7:0] rm,
        output int         lat
    );
        bus.go    = 1'b1;
        bus.left  = l;
        bus.right = r;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        lat    = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        q  = bus.out_quotient;
        rm = bus.out_remainder;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        bus.go = 1'b0;
        bus.left  = 8'h00;
        bus.right = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tests++;
        if (bus.done !== 1'b0 || bus.out_quotient !== 8'h00 ||
            bus.out_remainder !== 8'h00) begin
            fails++;
            $display("FAIL reset: done=%b q=%h r=%h want 0/00/00",
                     bus.done, bus.out_quotient, bus.out_remainder);
        end
    endtask

    task automatic test_basic;
        logic [7:0] q, rm;
        int lat;
        run_op(8'h18, 8'h08, q, rm, lat);
        tests++;
        if (lat !== 13) begin
            fails++;
            $display("FAIL basic_latency: got %0d want 13", lat);
        end
        tests++;
        if (q !== 8'h30 || rm !== 8'h00) begin
            fails++;
            $display("FAIL basic: q=%h r=%h want 30/00", q, rm);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL done_width: done=%b want 0", bus.done);
        end
        tests++;
        if (bus.out_quotient !== 8'h30) begin
            fails++;
            $display("FAIL hold: q=%h want 30", bus.out_quotient);
        end
    endtask

    task automatic test_signs;
        logic [7:0] tl [8] = '{8'hE8, 8'h10, 8'hF0, 8'h40, 8'h80, 8'h80, 8'h18, 8'h70};
        logic [7:0] tr [8] = '{8'h08, 8'h30, 8'h30, 8'h80, 8'h80, 8'h10, 8'h00, 8'h01};
        logic [7:0] eq [8] = '{8'hD0, 8'h05, 8'hFB, 8'hF8, 8'h10, 8'h80, 8'h00, 8'h00};
        logic [7:0] er [8] = '{8'h00, 8'h10, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h18, 8'h00};
        logic [7:0] q, rm;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(tl[i], tr[i], q, rm, lat);
            tests++;
            if (q !== eq[i] || rm !== er[i] || lat !== 13) begin
                fails++;
                $display("FAIL vec%0d %h/%h: q=%h r=%h lat=%0d want %h/%h lat 13",
                         i, tl[i], tr[i], q, rm, lat, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_busy_change;
        logic [7:0] prev;
        logic       moved;
        int         lat;
        prev  = bus.out_quotient;
        moved = 1'b0;
        bus.go    = 1'b1;
        bus.left  = 8'h10;
        bus.right = 8'h30;
        @(posedge clk);
        #1;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            bus.go    = 1'b1;
            bus.left  = 8'h7F ^ 8'(c);
            bus.right = 8'h01 + 8'(c);
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.out_quotient !== prev) moved = 1'b1;
        end
        bus.go = 1'b0;
        tests++;
        if (moved !== 1'b0) begin
            fails++;
            $display("FAIL busy_hold: output moved during BUSY, want %h", prev);
        end
        tests++;
        if (lat !== 13 || bus.out_quotient !== 8'h05 ||
            bus.out_remainder !== 8'h10) begin
            fails++;
            $display("FAIL busy_change: q=%h r=%h lat=%0d want 05/10 lat 13",
                     bus.out_quotient, bus.out_remainder, lat);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int  idx [3];
        int  n;
        int  wide;
        logic pd;
        n    = 0;
        wide = 0;
        pd   = 1'b0;
        bus.go    = 1'b1;
        bus.left  = 8'h18;
        bus.right = 8'h08;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 60 && n < 3; c++) begin
            @(posedge clk);
            #1;
            if (bus.done && pd) wide++;
            if (bus.done) begin
                idx[n] = c;
                n++;
            end
            pd = bus.done;
        end
        bus.go = 1'b0;
        tests++;
        if (n !== 3 || idx[0] !== 13 || idx[1] - idx[0] !== 14 ||
            idx[2] - idx[1] !== 14) begin
            fails++;
            $display("FAIL b2b_period: n=%0d first=%0d gaps=%0d,%0d want 3/13/14,14",
                     n, idx[0], idx[1] - idx[0], idx[2] - idx[1]);
        end
        tests++;
        if (wide !== 0) begin
            fails++;
            $display("FAIL b2b_width: %0d wide pulses want 0", wide);
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop;
        logic [7:0] q, rm;
        int lat;
        int seen;
        bus.go    = 1'b1;
        bus.left  = 8'hE8;
        bus.right = 8'h08;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tests++;
        if (bus.done !== 1'b0 || bus.out_quotient !== 8'h00 ||
            bus.out_remainder !== 8'h00) begin
            fails++;
            $display("FAIL midop_reset: done=%b q=%h r=%h want 0/00/00",
                     bus.done, bus.out_quotient, bus.out_remainder);
        end
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL midop_nodone: %0d pulses want 0", seen);
        end
        run_op(8'h10, 8'h30, q, rm, lat);
        tests++;
        if (q !== 8'h05 || rm !== 8'h10 || lat !== 13) begin
            fails++;
            $display("FAIL after_reset: q=%h r=%h lat=%0d want 05/10 lat 13",
                     q, rm, lat);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.go    = 1'b0;
        bus.left  = 8'h00;
        bus.right = 8'h00;
        @(posedge clk);
        #1;
        test_reset;
        test_basic;
        test_signs;
        test_busy_change;
        test_back_to_back;
        test_reset_midop;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
